// File: rtl/lsu_mem_port.sv
// Load/store unit for the memory stage: accepts one request per three cycles
// and drives the data-memory bus. Optional stack pointer for PUSH/POP (LSU_STACK_EN).
// Ports: clk, rst_n; req_valid/req_ready/req_op/req_addr/req_wdata (request);
//   rsp_valid/rsp_data/rsp_err (response); mem_read/mem_write/mem_address/
//   mem_write_data/mem_read_data (memory bus); sp (stack pointer, 0 when disabled).
module lsu_mem_port #(
  parameter logic [7:0] SP_RESET = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       mem_read,
  output logic       mem_write,
  output logic [7:0] mem_address,
  output logic [7:0] mem_write_data,
  input  logic [7:0] mem_read_data,
  output logic [7:0] sp
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_PUSH  = 2'b10;
  localparam logic [1:0] OP_POP   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] op_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] ea;
  logic       acc;
  logic       illegal;
  logic       is_rd;
  logic       is_wr;

  assign acc = req_valid && req_ready;

`ifdef LSU_STACK_EN
  logic [7:0] sp_q;

  assign illegal = 1'b0;
  assign sp      = sp_q;

  always_comb begin
    ea = req_addr;
    unique case (req_op)
      OP_PUSH: ea = sp_q - 8'd1;
      OP_POP:  ea = sp_q;
      default: ea = req_addr;
    endcase
  end

  // Wraps modulo 256 in both directions without any flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= SP_RESET;
    end else if (acc) begin
      if (req_op == OP_PUSH) sp_q <= sp_q - 8'd1;
      else if (req_op == OP_POP) sp_q <= sp_q + 8'd1;
    end
  end
`else
  logic unused_sp;

  assign unused_sp = ^SP_RESET;
  assign illegal   = op_q[1];
  assign sp        = 8'h00;
  assign ea        = req_addr;
`endif

  assign is_rd = !illegal &&
                 (op_q == OP_LOAD || op_q == OP_POP);
  assign is_wr = !illegal &&
                 (op_q == OP_STORE || op_q == OP_PUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (acc) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    mem_read  = (state == ACCESS) && is_rd;
    mem_write = (state == ACCESS) && is_wr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_LOAD;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      rsp_data <= 8'h00;
      rsp_err  <= 1'b0;
    end else begin
      if (acc) begin
        op_q    <= req_op;
        addr_q  <= ea;
        wdata_q <= req_wdata;
      end
      if (state == ACCESS) begin
        rsp_data <= is_rd ? mem_read_data : 8'h00;
        rsp_err  <= illegal;
      end
    end
  end

  // Bus lines come straight from the latched request so they hold between accesses.
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;

endmodule
